// File: rtl/audio_clkgen_nco.sv
// ---------------------------------------------------------------------------
// audio_clkgen_nco
//
// Purpose:
//   All-digital audio clock generator. Each of NUM_CLKS channels owns a
//   phase accumulator (NCO) that adds its active increment every refclk
//   cycle. The registered accumulator MSB is a ~50% duty square wave, and
//   the registered carry is a one-cycle clock-enable strobe. Increments can
//   be reprogrammed at runtime. A new value waits in a per-channel pending
//   slot and is only applied when the channel wraps, so the output never
//   glitches. A small FSM reports lock once every channel has run on a
//   stable increment for LOCK_CYCLES cycles.
//
// Parameters:
//   NUM_CLKS    number of output channels (1..8)
//   ACC_W       accumulator width (8..48)
//   INC_DEFAULT reset increments, channel i at [i*ACC_W +: ACC_W]
//   LOCK_CYCLES stable cycles required before locked asserts (>=1)
//   SEL_W       width of cfg_sel
//
// Ports:
//   refclk     in   reference clock, the only clock
//   rst        in   asynchronous active-low reset
//   sync_req   in   phase-align request (only with AUDIO_CLKGEN_PHASE_SYNC_EN)
//   cfg_wr     in   one-cycle write strobe for a new increment
//   cfg_sel    in   target channel of the write (out-of-range is ignored)
//   cfg_inc    in   new increment value
//   cfg_ack    out  per-channel pulse, one cycle after a pending value applies
//   outclk     out  per-channel registered accumulator MSB
//   outclk_en  out  per-channel registered wrap strobe
//   locked     out  all channels stable for LOCK_CYCLES cycles
//
// Optional feature macro: AUDIO_CLKGEN_PHASE_SYNC_EN
//   Adds sync_req. When sync_req is high, all accumulators clear on the next
//   edge. Pending increments apply at that edge, and outclk_en is suppressed.
// ---------------------------------------------------------------------------
module audio_clkgen_nco #(
    parameter int                          NUM_CLKS    = 2,
    parameter int                          ACC_W       = 32,
    parameter logic [NUM_CLKS*ACC_W-1:0]   INC_DEFAULT = {32'd175921860, 32'd1055531163},
    parameter int                          LOCK_CYCLES = 1024,
    parameter int                          SEL_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
    input  logic                sync_req,
`endif
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CLKS-1:0] cfg_ack,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outclk_en,
    output logic                locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        ST_SETTLE,
        ST_LOCKED
    } lockState_t;

    logic [ACC_W-1:0]    r_acc    [NUM_CLKS];
    logic [ACC_W-1:0]    r_incAct [NUM_CLKS];
    logic [ACC_W-1:0]    r_pend   [NUM_CLKS];
    logic [NUM_CLKS-1:0] r_pendV;
    logic [NUM_CLKS-1:0] r_outclk;
    logic [NUM_CLKS-1:0] r_outclkEn;
    logic [NUM_CLKS-1:0] r_cfgAck;

    logic [ACC_W:0]      w_sum     [NUM_CLKS];
    logic [ACC_W-1:0]    w_accNext [NUM_CLKS];
    logic [NUM_CLKS-1:0] w_carry;
    logic [NUM_CLKS-1:0] w_stopped;
    logic [NUM_CLKS-1:0] w_apply;
    logic [NUM_CLKS-1:0] w_incChange;
    logic [NUM_CLKS-1:0] w_write;
    logic                w_sync;

    lockState_t          r_state;
    lockState_t          w_stateNext;
    logic [CNT_W-1:0]    r_lockCnt;
    logic [CNT_W-1:0]    w_lockCntNext;

`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
    assign w_sync = sync_req;
`else
    assign w_sync = 1'b0;
`endif

    // Per-channel datapath decisions.
    // A pending increment is applied at the wrap edge, so the new frequency
    // starts on a clean period boundary. A stopped channel (increment 0)
    // never wraps, so it applies on the very next cycle and restarts from 0.
    // A sync request behaves like a forced wrap of every channel.
    // The write decode compares against each valid index. Selects at or
    // above NUM_CLKS therefore match nothing and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CLKS; i++) begin
            w_sum[i]       = {1'b0, r_acc[i]} + {1'b0, r_incAct[i]};
            w_carry[i]     = w_sum[i][ACC_W];
            w_stopped[i]   = (r_incAct[i] == '0);
            w_apply[i]     = r_pendV[i] & (w_carry[i] | w_stopped[i] | w_sync);
            w_incChange[i] = w_apply[i] & (r_pend[i] != r_incAct[i]);
            w_write[i]     = cfg_wr & (cfg_sel == SEL_W'(i));
            if (w_stopped[i] || w_sync) begin
                w_accNext[i] = '0;
            end else begin
                w_accNext[i] = w_sum[i][ACC_W-1:0];
            end
        end
    end

    // Accumulators, registered outputs, and the pending-increment slots.
    // If a write and an apply hit the same channel in one cycle, the old
    // pending value is consumed by the apply, and the new write stays
    // pending. That is why the write branch takes priority for r_pendV.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                r_acc[i]    <= '0;
                r_incAct[i] <= INC_DEFAULT[i*ACC_W +: ACC_W];
                r_pend[i]   <= '0;
            end
            r_pendV    <= '0;
            r_outclk   <= '0;
            r_outclkEn <= '0;
            r_cfgAck   <= '0;
        end else begin
            for (int i = 0; i < NUM_CLKS; i++) begin
                r_acc[i]      <= w_accNext[i];
                r_outclk[i]   <= w_accNext[i][ACC_W-1];
                r_outclkEn[i] <= w_carry[i] & ~w_stopped[i] & ~w_sync;
                r_cfgAck[i]   <= w_apply[i];
                if (w_apply[i]) begin
                    r_incAct[i] <= r_pend[i];
                end
                if (w_write[i]) begin
                    r_pend[i]  <= cfg_inc;
                    r_pendV[i] <= 1'b1;
                end else if (w_apply[i]) begin
                    r_pendV[i] <= 1'b0;
                end
            end
        end
    end

    // Lock FSM state register.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SETTLE;
            r_lockCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_lockCnt <= w_lockCntNext;
        end
    end

    // Lock FSM next state.
    // Re-applying an identical increment does not disturb lock. Only a real
    // frequency change restarts settling. With every channel stopped there
    // is nothing to lock to, so the FSM is parked in SETTLE at count 0.
    always_comb begin
        w_stateNext   = r_state;
        w_lockCntNext = r_lockCnt;
        if ((|w_incChange) || (&w_stopped)) begin
            w_stateNext   = ST_SETTLE;
            w_lockCntNext = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_lockCnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        w_stateNext = ST_LOCKED;
                    end else begin
                        w_lockCntNext = r_lockCnt + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    w_stateNext = ST_LOCKED;
                end
                default: begin
                    w_stateNext   = ST_SETTLE;
                    w_lockCntNext = '0;
                end
            endcase
        end
    end

    assign outclk    = r_outclk;
    assign outclk_en = r_outclkEn;
    assign cfg_ack   = r_cfgAck;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_audio_clkgen_nco.sv
// ---------------------------------------------------------------------------
// tb_audio_clkgen_nco
//
// Scoreboard bench for audio_clkgen_nco with an 8-bit accumulator, two
// channels, reset increments 64 (ch0) and 16 (ch1), and LOCK_CYCLES = 8.
// cfg_sel is widened to 2 bits so that out-of-range selects (2, 3) can be
// driven. The stimulus process drives one cycle at a time. For each cycle
// it advances a behavioural model and queues the outputs expected after
// the next rising edge. A monitor pops the queue just after every rising
// edge and compares.
// ---------------------------------------------------------------------------
module tb_audio_clkgen_nco;

    localparam int NCLK  = 2;
    localparam int AW    = 8;
    localparam int MOD   = 256;
    localparam int LOCKC = 8;

    typedef struct packed {
        logic [1:0] clk;
        logic [1:0] en;
        logic [1:0] ack;
        logic       lk;
    } exp_t;

    logic          refclk = 1'b0;
    logic          rst    = 1'b1;
    logic          cfgWr  = 1'b0;
    logic [1:0]    cfgSel = 2'd0;
    logic [AW-1:0] cfgInc = '0;
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
    logic          syncReq = 1'b0;
`endif
    logic [1:0]    cfgAck;
    logic [1:0]    outclk;
    logic [1:0]    outclkEn;
    logic          locked;

    int   checkCount = 0;
    int   errCount   = 0;
    exp_t expQ[$];
    exp_t monExp;

    // Model state: phase, active increment, and pending slot per channel,
    // plus the stable-cycle counter behind locked.
    int   mAcc   [NCLK];
    int   mInc   [NCLK];
    int   mPend  [NCLK];
    bit   mPendV [NCLK];
    int   mCnt;
    bit   mLocked;

    audio_clkgen_nco #(
        .NUM_CLKS    (NCLK),
        .ACC_W       (AW),
        .INC_DEFAULT ({8'd16, 8'd64}),
        .LOCK_CYCLES (LOCKC),
        .SEL_W       (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
        .sync_req  (syncReq),
`endif
        .cfg_wr    (cfgWr),
        .cfg_sel   (cfgSel),
        .cfg_inc   (cfgInc),
        .cfg_ack   (cfgAck),
        .outclk    (outclk),
        .outclk_en (outclkEn),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < NCLK; i++) begin
            mAcc[i]   = 0;
            mPend[i]  = 0;
            mPendV[i] = 0;
        end
        mInc[0] = 64;
        mInc[1] = 16;
        mCnt    = 0;
        mLocked = 0;
    endfunction

    // One refclk cycle of the reference behaviour, computed with integer
    // phase arithmetic. The outputs expected after the edge are queued.
    function automatic void modelStep(input bit wr, input int sel, input int inc, input bit sync);
        exp_t e;
        bit   changed;
        bit   allStopped;
        int   total;
        bit   wrapped;
        bit   stopped;
        bit   apply;
        e          = '0;
        changed    = 0;
        allStopped = 1;
        for (int i = 0; i < NCLK; i++) begin
            total   = mAcc[i] + mInc[i];
            wrapped = (total >= MOD);
            stopped = (mInc[i] == 0);
            apply   = mPendV[i] && (wrapped || stopped || sync);
            if (!stopped) allStopped = 0;
            mAcc[i]  = (stopped || sync) ? 0 : (total % MOD);
            e.clk[i] = (mAcc[i] >= MOD / 2);
            e.en[i]  = wrapped && !sync;
            e.ack[i] = apply;
            if (apply) begin
                if (mPend[i] != mInc[i]) changed = 1;
                mInc[i]   = mPend[i];
                mPendV[i] = 0;
            end
            if (wr && sel == i) begin
                mPend[i]  = inc;
                mPendV[i] = 1;
            end
        end
        if (changed || allStopped) begin
            mCnt    = 0;
            mLocked = 0;
        end else if (!mLocked) begin
            if (mCnt == LOCKC - 1) mLocked = 1;
            else mCnt++;
        end
        e.lk = mLocked;
        expQ.push_back(e);
    endfunction

    // Drive one cycle of inputs on the falling edge and queue its expectation.
    task automatic applyStimulus(input bit wr, input int sel, input int inc, input bit sync);
        @(negedge refclk);
        cfgWr  = wr;
        cfgSel = 2'(sel);
        cfgInc = AW'(inc);
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
        syncReq = sync;
`endif
        modelStep(wr, sel, inc, sync);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, and releases
    // it just after a rising edge so the model and DUT restart together.
    task automatic doReset();
        @(negedge refclk);
        #2;
        rst   = 1'b0;
        cfgWr = 1'b0;
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
        syncReq = 1'b0;
`endif
        #1;
        checkOutput("rstOutclk",   8'(outclk),   8'h0);
        checkOutput("rstOutclkEn", 8'(outclkEn), 8'h0);
        checkOutput("rstCfgAck",   8'(cfgAck),   8'h0);
        checkOutput("rstLocked",   8'(locked),   8'h0);
        modelReset();
        repeat (2) @(posedge refclk);
        #2;
        rst = 1'b1;
    endtask

    function automatic int pickInc();
        case ($urandom_range(0, 6))
            0:       return 0;
            1:       return 8;
            2:       return 16;
            3:       return 32;
            4:       return 64;
            5:       return 128;
            default: return int'($urandom_range(1, 255));
        endcase
    endfunction

    // Monitor: one expected record per refclk edge while out of reset.
    initial begin
        forever begin
            @(posedge refclk);
            #1;
            if (expQ.size() > 0) begin
                monExp = expQ.pop_front();
                checkOutput("outclk",    8'(outclk),   8'(monExp.clk));
                checkOutput("outclk_en", 8'(outclkEn), 8'(monExp.en));
                checkOutput("cfg_ack",   8'(cfgAck),   8'(monExp.ack));
                checkOutput("locked",    8'(locked),   8'(monExp.lk));
            end
        end
    end

    initial begin
        int  r;
        bit  doSync;
        doReset();
        $display("[TB] default increments and lock sequencing");
        idle(40);

        $display("[TB] ch0 reprogrammed to 32 mid-period");
        idle(1);
        applyStimulus(1, 0, 32, 0);
        idle(40);

        $display("[TB] ch1 double write, last value wins");
        applyStimulus(1, 1, 8, 0);
        idle(2);
        applyStimulus(1, 1, 128, 0);
        idle(40);

        $display("[TB] both channels stopped, then ch0 restarted");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0);
        idle(40);
        applyStimulus(1, 0, 64, 0);
        idle(30);

        $display("[TB] out-of-range select and same-value rewrite");
        applyStimulus(1, 3, 5, 0);
        applyStimulus(1, 2, 200, 0);
        idle(20);
        applyStimulus(1, 0, 64, 0);
        idle(20);

        $display("[TB] back-to-back writes colliding with applies");
        for (int k = 0; k < 12; k++) applyStimulus(1, 0, (k % 2 == 0) ? 32 : 64, 0);
        idle(30);

`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
        $display("[TB] phase sync pulse");
        applyStimulus(1, 1, 16, 0);
        idle(5);
        applyStimulus(0, 0, 0, 1);
        idle(40);
`endif

        $display("[TB] reset mid-period");
        idle(3);
        doReset();
        idle(20);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2500; k++) begin
            r      = int'($urandom_range(0, 39));
            doSync = 0;
`ifdef AUDIO_CLKGEN_PHASE_SYNC_EN
            doSync = ($urandom_range(0, 49) == 0);
`endif
            if ($urandom_range(0, 999) == 0) begin
                doReset();
            end else if (r == 0) begin
                applyStimulus(1, int'($urandom_range(0, 3)), pickInc(), doSync);
            end else begin
                applyStimulus(0, 0, 0, doSync);
            end
        end

        @(posedge refclk);
        #3;
        checkOutput("scoreDrain", 8'(expQ.size()), 8'h0);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
